// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, instruction memory and IF/ID register.
// Adds flush, redirect-over-stall, HALT freeze and debug programming.
module if_fetch_unit #(
  parameter int unsigned PC_W       = 32,
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned IMEM_AW    = $clog2(IMEM_DEPTH),
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_clk_en,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic               i_pcsrc,
  input  logic [PC_W-1:0]    i_branch_addr,
  input  logic               i_jump,
  input  logic [PC_W-1:0]    i_jump_addr,
  input  logic               i_prog_en,
  input  logic               i_prog_we,
  input  logic [IMEM_AW-1:0] i_prog_addr,
  input  logic [31:0]        i_prog_data,
  output logic [PC_W-1:0]    o_pc,
  output logic [PC_W-1:0]    o_pc_plus_4,
  output logic [31:0]        o_instruction,
  output logic               o_valid,
  output logic               o_halted
);

  typedef enum logic [2:0] {
    A_PROG,
    A_REDIR,
    A_FLUSH,
    A_HALT,
    A_STALL,
    A_FETCH
  } act_e;

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

  logic [31:0]        mem_q [IMEM_DEPTH];

  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    pc_d;
  logic [PC_W-1:0]    pc4_q;
  logic [PC_W-1:0]    pc4_d;
  logic [31:0]        instr_q;
  logic [31:0]        instr_d;
  logic               valid_q;
  logic               valid_d;
  logic               halted_q;
  logic               halted_d;

  logic [IMEM_AW-1:0] rd_addr;
  logic [31:0]        rd_word;
  logic [PC_W-1:0]    pc_inc;
  logic [PC_W-1:0]    redir_pc;
  logic               redirect;
  logic               rd_is_halt;
  act_e               act;

  // Word addressing; upper PC bits are dropped so fetch wraps.
  assign rd_addr    = pc_q[IMEM_AW+1:2];
  assign rd_word    = mem_q[rd_addr];
  assign rd_is_halt = (rd_word == HALT_WORD);
  assign pc_inc     = pc_q + PC_STEP;
  assign redirect   = i_jump | i_pcsrc;
  assign redir_pc   = i_jump ? i_jump_addr
                             : i_branch_addr;

  always_ff @(posedge i_clk) begin
    if (i_prog_en && i_prog_we) begin
      mem_q[i_prog_addr] <= i_prog_data;
    end
  end

  always_comb begin
    act = A_FETCH;
    if (i_prog_en) begin
      act = A_PROG;
    end else if (redirect) begin
      act = A_REDIR;
    end else if (i_flush) begin
      act = A_FLUSH;
    end else if (halted_q) begin
      act = A_HALT;
    end else if (i_stall) begin
      act = A_STALL;
    end
  end

  always_comb begin
    pc_d     = pc_q;
    pc4_d    = pc4_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    if (i_clk_en) begin
      unique case (act)
        A_PROG: begin
          pc_d     = '0;
          instr_d  = NOP_WORD;
          valid_d  = 1'b0;
          halted_d = 1'b0;
        end
        A_REDIR: begin
          pc_d     = redir_pc;
          instr_d  = NOP_WORD;
          valid_d  = 1'b0;
          halted_d = 1'b0;
        end
        A_FLUSH: begin
          instr_d = NOP_WORD;
          valid_d = 1'b0;
          if (!i_stall && !halted_q) begin
            pc_d = pc_inc;
          end
        end
        A_HALT: begin
          instr_d = NOP_WORD;
          valid_d = 1'b0;
        end
        A_STALL: begin
        end
        A_FETCH: begin
          instr_d = rd_word;
          pc4_d   = pc_inc;
          valid_d = 1'b1;
          // The HALT word issues once; PC parks on its address.
          if (rd_is_halt) begin
            halted_d = 1'b1;
          end else begin
            pc_d = pc_inc;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      pc_q     <= '0;
      pc4_q    <= '0;
      instr_q  <= NOP_WORD;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      pc4_q    <= pc4_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign o_pc          = pc_q;
  assign o_pc_plus_4   = pc4_q;
  assign o_instruction = instr_q;
  assign o_valid       = valid_q;
  assign o_halted      = halted_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed plus random bench for if_fetch_unit against a
// rule-level reference model of the fetch stage.
module tb_if_fetch_unit;

  localparam int DEPTH = 16;
  localparam logic [31:0] HALTW = 32'hFFFF_FFFF;

  logic        clk;
  logic        rst;
  logic        clk_en;
  logic        stall;
  logic        flush;
  logic        pcsrc;
  logic [31:0] baddr;
  logic        jump;
  logic [31:0] jaddr;
  logic        prog_en;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [31:0] prog_data;
  logic [31:0] o_pc;
  logic [31:0] o_pc4;
  logic [31:0] o_instr;
  logic        o_valid;
  logic        o_halted;

  int n_cmp;
  int n_bad;

  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_pc;
  logic [31:0] m_pc4;
  logic [31:0] m_instr;
  logic        m_valid;
  logic        m_halted;

  if_fetch_unit #(.IMEM_DEPTH(DEPTH)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_clk_en     (clk_en),
    .i_stall      (stall),
    .i_flush      (flush),
    .i_pcsrc      (pcsrc),
    .i_branch_addr(baddr),
    .i_jump       (jump),
    .i_jump_addr  (jaddr),
    .i_prog_en    (prog_en),
    .i_prog_we    (prog_we),
    .i_prog_addr  (prog_addr),
    .i_prog_data  (prog_data),
    .o_pc         (o_pc),
    .o_pc_plus_4  (o_pc4),
    .o_instruction(o_instr),
    .o_valid      (o_valid),
    .o_halted     (o_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".pc"}, o_pc, m_pc);
    chk({tag, ".pc4"}, o_pc4, m_pc4);
    chk({tag, ".instr"}, o_instr, m_instr);
    chk({tag, ".valid"}, 32'(o_valid), 32'(m_valid));
    chk({tag, ".halted"}, 32'(o_halted), 32'(m_halted));
  endtask

  task automatic m_reset();
    m_pc     = 0;
    m_pc4    = 0;
    m_instr  = 0;
    m_valid  = 0;
    m_halted = 0;
  endtask

  // One rising edge applied to the model, rule by rule.
  task automatic m_edge();
    int unsigned widx;
    logic [31:0] word;
    widx = (m_pc / 4) % DEPTH;
    word = m_mem[widx];
    if (!rst) begin
      m_reset();
    end else if (clk_en) begin
      if (prog_en) begin
        m_pc = 0;
        m_instr = 0;
        m_valid = 0;
        m_halted = 0;
      end else if (jump || pcsrc) begin
        m_pc = jump ? jaddr : baddr;
        m_instr = 0;
        m_valid = 0;
        m_halted = 0;
      end else if (flush) begin
        m_instr = 0;
        m_valid = 0;
        if (!stall && !m_halted) m_pc = m_pc + 4;
      end else if (m_halted) begin
        m_instr = 0;
        m_valid = 0;
      end else if (!stall) begin
        m_instr = word;
        m_pc4 = m_pc + 4;
        m_valid = 1;
        if (word == HALTW) m_halted = 1;
        else m_pc = m_pc + 4;
      end
    end
    if (prog_en && prog_we) m_mem[prog_addr] = prog_data;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    m_edge();
    #1;
    chk_all(tag);
  endtask

  task automatic idle();
    clk_en = 1; stall = 0; flush = 0;
    pcsrc = 0; jump = 0; baddr = 0; jaddr = 0;
    prog_en = 0; prog_we = 0;
    prog_addr = 0; prog_data = 0;
  endtask

  task automatic prog(input int a, input logic [31:0] d);
    prog_en = 1; prog_we = 1;
    prog_addr = 4'(a); prog_data = d;
    step("prog");
    idle();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    idle();
    m_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
    rst = 1;
    #1 rst = 0;
    #2;
    chk_all("reset");
    step("reset_hold");
    @(negedge clk);
    rst = 1;

    for (int i = 0; i < DEPTH; i++)
      prog(i, (i < 4) ? 32'(32'h11 * (i + 1))
                      : 32'(32'h100 + i));

    step("seq0");
    chk("seq0.instr", o_instr, 32'h11);
    chk("seq0.pc", o_pc, 32'h4);
    step("seq1");
    chk("seq1.instr", o_instr, 32'h22);
    chk("seq1.pc4", o_pc4, 32'h8);

    stall = 1;
    step("stall0");
    step("stall1");
    chk("stall.pc", o_pc, 32'h8);
    chk("stall.instr", o_instr, 32'h22);
    stall = 0;
    step("resume");
    chk("resume.instr", o_instr, 32'h33);

    jump = 1; jaddr = 32'h40;
    pcsrc = 1; baddr = 32'h20; stall = 1;
    step("redir");
    chk("redir.pc", o_pc, 32'h40);
    chk("redir.valid", 32'(o_valid), 0);
    idle();
    step("redir_fetch");
    chk("redir_fetch.instr", o_instr, 32'h11);

    prog(2, HALTW);
    step("h0");
    step("h1");
    step("h2");
    chk("halt.instr", o_instr, HALTW);
    chk("halt.flag", 32'(o_halted), 1);
    chk("halt.pc", o_pc, 32'h8);
    step("h3");
    chk("halt.bubble", 32'(o_valid), 0);
    stall = 1; flush = 1;
    step("h4");
    idle();
    step("h5");
    pcsrc = 1; baddr = 0;
    step("unhalt");
    chk("unhalt.flag", 32'(o_halted), 0);
    idle();
    step("unhalt_fetch");
    chk("unhalt.instr", o_instr, 32'h11);

    pcsrc = 1; baddr = 32'h44;
    step("wrap_br");
    idle();
    step("wrap");
    chk("wrap.instr", o_instr, 32'h22);

    jump = 1; jaddr = 32'hFFFF_FFFC;
    step("pcw_j");
    idle();
    step("pcw");
    chk("pcw.pc4", o_pc4, 32'h0);
    chk("pcw.instr", o_instr, 32'h10F);

    flush = 1;
    step("flush");
    stall = 1;
    step("flush_stall");
    idle();
    clk_en = 0;
    stall = 1;
    step("clk_off");
    idle();

    prog(2, 32'h33);
    step("a0");
    step("a1");
    step("a2");
    chk("async.pc_pre", o_pc, 32'hC);
    #1 rst = 0;
    #1;
    m_reset();
    chk_all("async");
    chk("async.pc", o_pc, 32'h0);
    #1 rst = 1;

    for (int n = 0; n < 400; n++) begin
      clk_en  = ($urandom_range(9) != 0);
      stall   = ($urandom_range(4) == 0);
      flush   = ($urandom_range(9) == 0);
      pcsrc   = ($urandom_range(11) == 0);
      jump    = ($urandom_range(19) == 0);
      baddr   = 32'($urandom_range(31)) * 4;
      jaddr   = ($urandom_range(7) == 0) ? $urandom
                : 32'($urandom_range(31)) * 4;
      prog_en = ($urandom_range(19) == 0);
      prog_we = ($urandom_range(1) == 0);
      prog_addr = 4'($urandom_range(15));
      prog_data = ($urandom_range(5) == 0) ? HALTW
                                           : $urandom;
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Parametrised instruction-fetch stage for the 5-stage MIPS pipeline.
- Holds the PC, the instruction memory and the registered IF/ID outputs (instruction, PC+4, valid).
- Adds the following over the current fetch stage: configurable PC width and memory depth, a flush/bubble path, redirect priority over stall, HALT detection with fetch freeze, and a debug programming mode that rewinds the PC.
- Branch and jump targets are computed downstream and supplied as inputs.

Parameters:
- PC_W, 32, width of PC, targets and PC+4.
- IMEM_DEPTH, 256, instruction memory depth in 32-bit words; must be a power of two.
- IMEM_AW, $clog2(IMEM_DEPTH), word-address width.
- NOP_WORD, 32'h0000_0000, value driven on o_instruction for a bubble.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that halts fetch.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_clk_en  in  1  advances PC and the IF/ID register when 1.
- i_stall  in  1  holds PC and IF/ID (hazard unit).
- i_flush  in  1  squashes the instruction currently being fetched.
- i_pcsrc  in  1  branch-taken redirect.
- i_branch_addr  in  PC_W  branch target.
- i_jump  in  1  jump redirect.
- i_jump_addr  in  PC_W  jump target.
- i_prog_en  in  1  debug programming mode.
- i_prog_we  in  1  memory write strobe, valid only in programming mode.
- i_prog_addr  in  IMEM_AW  word address to write.
- i_prog_data  in  32  word to write.
- o_pc  out  PC_W  current PC.
- o_pc_plus_4  out  PC_W  registered PC+4 of the fetched instruction.
- o_instruction  out  32  registered fetched instruction.
- o_valid  out  1  o_instruction is a real instruction.
- o_halted  out  1  HALT fetched; fetch frozen.

Behaviour:
- **Reset** (i_reset=0, async): o_pc=0, o_pc_plus_4=0, o_instruction=NOP_WORD, o_valid=0, o_halted=0. Memory contents are not cleared.
- **Memory read:** memory is indexed by word, mem[pc[IMEM_AW+1:2]]. PC bits above that range are ignored, so addressing wraps modulo IMEM_DEPTH*4. pc[1:0] is ignored.
- **Edge action:** all actions below occur at the rising edge with i_clk_en=1, evaluated in priority order. With i_clk_en=0 nothing changes except programming writes.
  1. **Programming mode** (i_prog_en=1):
     - If i_prog_we=1: mem[i_prog_addr] <= i_prog_data.
     - o_pc <= 0, o_valid <= 0, o_instruction <= NOP_WORD, o_halted <= 0.
     - Programming writes occur regardless of i_clk_en.
  2. **Redirect** (i_jump or i_pcsrc):
     - o_pc <= i_jump ? i_jump_addr : i_branch_addr. Jump wins over branch.
     - o_instruction <= NOP_WORD, o_valid <= 0, o_halted <= 0.
     - A redirect overrides i_stall and halt.
  3. **Flush** without redirect:
     - o_instruction <= NOP_WORD, o_valid <= 0.
     - o_pc <= o_pc + 4, unless stalled or halted, in which case o_pc holds.
  4. **Halted:**
     - PC and o_pc_plus_4 hold.
     - o_instruction <= NOP_WORD, o_valid <= 0.
  5. **Stall:** PC and all IF/ID outputs hold.
  6. **Normal fetch:**
     - o_instruction <= mem word, o_pc_plus_4 <= o_pc + 4, o_valid <= 1, o_pc <= o_pc + 4.
     - PC+4 wraps modulo 2^PC_W.
- **HALT detection:** in normal fetch, if the read word equals HALT_WORD:
  - the HALT instruction is issued once (o_valid=1);
  - o_halted <= 1 on the same edge and o_pc stays at the HALT address;
  - from the next cycle only bubbles are issued.
- **Leaving halt:** o_halted is cleared only by reset, programming mode or a redirect.
- **Latency:** the instruction at address A appears on o_instruction one clock after o_pc=A. Branch penalty is 1 bubble after redirect.
- **Simultaneous events:**
  - stall + flush: flush wins for the outputs, PC holds.
  - prog_en asserted mid-stream: the in-flight instruction is dropped.
  - prog_en 1->0: fetch resumes from PC 0 on the next enabled edge.

Test Plan:
1. **Reset/sequential fetch:** reset, program mem[0..3]=0x11,0x22,0x33,0x44 via prog mode, drop prog_en. Required: o_pc 0,4,8,12; o_instruction 0x11,0x22,0x33,0x44 each one cycle later with o_valid=1; o_pc_plus_4=4,8,12,16.
2. **Stall:** assert i_stall 2 cycles while o_pc=8. Required: o_pc stays 8, o_instruction stays 0x22, o_valid stays 1; fetch resumes with 0x33.
3. **Redirect priority:** i_jump=1 with jump_addr=0x40 and i_pcsrc=1 with branch_addr=0x20, in the same cycle as i_stall=1. Required: o_pc=0x40, one NOP with o_valid=0, then mem[16].
4. **HALT:** mem[2]=0xFFFFFFFF. Required: HALT is issued with o_valid=1, o_halted=1, o_pc frozen at 8, NOP/o_valid=0 thereafter. A branch to 0 clears o_halted and refetches 0x11.
5. **Wrap-around:** IMEM_DEPTH=16, branch to 0x44. Required: fetches mem[1].
6. **Async reset mid-fetch:** drop i_reset between clock edges at o_pc=0x0C. Required: outputs return to reset values immediately, with no wait for a clock edge.
